// File: rtl/fp_issue_ctrl.sv
// Issue controller between a host request/response port and a single-cycle-issue FP ALU.
// One operation in flight, with a watchdog that answers with a quiet NaN if the ALU never responds.
module fp_issue_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_sub,
  input  logic        req_round_mode,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic [4:0]  resp_flags,
  output logic        resp_timeout,
  output logic [31:0] alu_op_a,
  output logic [31:0] alu_op_b,
  output logic [2:0]  alu_op_code,
  output logic        alu_mode_fp,
  output logic        alu_round_mode,
  output logic        alu_start,
  input  logic [31:0] alu_result,
  input  logic        alu_valid,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  fflags,
  input  logic        fflags_clr,
  output logic        busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic          sub_q, sub_d, mode_q, mode_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_result_q, resp_result_d;
  logic [4:0]    resp_flags_q, resp_flags_d;
  logic          resp_timeout_q, resp_timeout_d;
  logic [4:0]    fflags_q, fflags_d;
  logic          timeout_hit;

  assign timeout_hit = (state_q == WAIT) && ((cnt_q + CW'(1)) == TO_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      sub_q          <= 1'b0;
      mode_q         <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_result_q  <= '0;
      resp_flags_q   <= '0;
      resp_timeout_q <= 1'b0;
      fflags_q       <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      a_q            <= a_d;
      b_q            <= b_d;
      sub_q          <= sub_d;
      mode_q         <= mode_d;
      resp_valid_q   <= resp_valid_d;
      resp_result_q  <= resp_result_d;
      resp_flags_q   <= resp_flags_d;
      resp_timeout_q <= resp_timeout_d;
      fflags_q       <= fflags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = ISSUE;
      ISSUE:   state_d = alu_valid ? RESP : WAIT;
      WAIT: begin
        if (alu_valid)        state_d = RESP;
        else if (timeout_hit) state_d = DRAIN;
      end
      RESP:    if (resp_ready) state_d = IDLE;
      // Stay long enough for any late ALU answer to be swallowed here, not in IDLE.
      DRAIN:   if ((cnt_q == TO_CNT) && (!resp_valid_q || resp_ready)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic       capture;
    logic [4:0] cap_flags;
    capture        = 1'b0;
    cap_flags      = '0;
    cnt_d          = cnt_q;
    a_d            = a_q;
    b_d            = b_q;
    sub_d          = sub_q;
    mode_d         = mode_q;
    resp_valid_d   = resp_valid_q;
    resp_result_d  = resp_result_q;
    resp_flags_d   = resp_flags_q;
    resp_timeout_d = resp_timeout_q;

    if (state_q == IDLE && req_valid) begin
      a_d    = req_a;
      b_d    = req_b;
      sub_d  = req_sub;
      mode_d = req_round_mode;
    end

    if (resp_valid_q && resp_ready) resp_valid_d = 1'b0;

    unique case (state_q)
      ISSUE: cnt_d = '0;
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (timeout_hit && !alu_valid) cnt_d = '0;
      end
      DRAIN: if (cnt_q != TO_CNT) cnt_d = cnt_q + CW'(1);
      default: ;
    endcase

    if ((state_q == ISSUE || state_q == WAIT) && alu_valid) begin
      capture        = 1'b1;
      cap_flags      = alu_flags;
      resp_result_d  = alu_result;
      resp_timeout_d = 1'b0;
    end else if (timeout_hit) begin
      capture        = 1'b1;
      cap_flags      = 5'b01000;
      resp_result_d  = 32'h7FC0_0000;
      resp_timeout_d = 1'b1;
    end
    if (capture) begin
      resp_valid_d = 1'b1;
      resp_flags_d = cap_flags;
    end

    fflags_d = fflags_clr ? '0 : fflags_q;
    if (capture) fflags_d = fflags_d | cap_flags;
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    alu_start = (state_q == ISSUE);
  end

  assign alu_op_a       = a_q;
  assign alu_op_b       = {b_q[31] ^ sub_q, b_q[30:0]};
  assign alu_op_code    = 3'b000;
  assign alu_mode_fp    = 1'b1;
  assign alu_round_mode = mode_q;
  assign resp_valid     = resp_valid_q;
  assign resp_result    = resp_result_q;
  assign resp_flags     = resp_flags_q;
  assign resp_timeout   = resp_timeout_q;
  assign fflags         = fflags_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Bench for fp_issue_ctrl: a scripted ALU answers after a chosen latency, and the expected
// response, latency and sticky flags come from a transaction-level model.
module tb_fp_issue_ctrl;
  localparam int TO = 64;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_sub, req_round_mode;
  logic [31:0] req_a, req_b;
  logic        resp_valid, resp_ready, resp_timeout;
  logic [31:0] resp_result;
  logic [4:0]  resp_flags;
  logic [31:0] alu_op_a, alu_op_b, alu_result;
  logic [2:0]  alu_op_code;
  logic        alu_mode_fp, alu_round_mode, alu_start, alu_valid;
  logic [4:0]  alu_flags, fflags;
  logic        fflags_clr, busy;

  int total = 0;
  int bad = 0;
  logic [4:0] fflags_m;

  fp_issue_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_sub(req_sub), .req_round_mode(req_round_mode),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_flags(resp_flags), .resp_timeout(resp_timeout),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
    .alu_mode_fp(alu_mode_fp), .alu_round_mode(alu_round_mode), .alu_start(alu_start),
    .alu_result(alu_result), .alu_valid(alu_valid), .alu_flags(alu_flags),
    .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_result"}, resp_result, 0);
    chk({tag, "_resp_flags"}, resp_flags, 0);
    chk({tag, "_resp_timeout"}, resp_timeout, 0);
    chk({tag, "_alu_start"}, alu_start, 0);
    chk({tag, "_op_a"}, alu_op_a, 0);
    chk({tag, "_op_b"}, alu_op_b, 0);
    chk({tag, "_rm"}, alu_round_mode, 0);
    chk({tag, "_fflags"}, fflags, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  // lat: ALU answers in accept-cycle + 1 + lat; lat > TO means it never answers in time.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic mode, input int lat, input logic [31:0] ares,
                        input logic [4:0] aflg, input int bp, input logic clr);
    logic [31:0] exp_res, exp_b;
    logic [4:0]  exp_flg;
    logic        exp_to;
    int          exp_cyc, got, n;
    exp_to  = (lat > TO);
    exp_res = exp_to ? 32'h7FC0_0000 : ares;
    exp_flg = exp_to ? 5'b01000 : aflg;
    exp_cyc = exp_to ? TO + 2 : lat + 2;
    exp_b   = sub ? {~b[31], b[30:0]} : b;

    n = 0;
    while (!req_ready && n < 3 * TO) begin tick(); n++; end
    chk("req_ready_before_op", req_ready, 1);
    req_valid = 1'b1; req_a = a; req_b = b; req_sub = sub; req_round_mode = mode;
    tick();
    req_valid = 1'b0; req_a = $urandom(); req_b = $urandom();
    req_sub = 1'($urandom()); req_round_mode = 1'($urandom());
    chk("alu_start_issue", alu_start, 1);
    chk("op_code_fp", {alu_mode_fp, alu_op_code}, 4'b1000);
    chk("req_ready_busy", req_ready, 0);

    got = -1;
    for (int c = 1; c <= TO + 10; c++) begin
      if (resp_valid) begin got = c; break; end
      chk("op_a_stable", alu_op_a, a);
      chk("op_b_stable", alu_op_b, exp_b);
      chk("rm_stable", alu_round_mode, mode);
      if (c > 1) chk("alu_start_pulse", alu_start, 0);
      alu_valid  = (c == lat + 1);
      alu_result = alu_valid ? ares : $urandom();
      alu_flags  = alu_valid ? aflg : 5'($urandom());
      fflags_clr = clr && (alu_valid || (exp_to && c == TO + 1));
      tick();
    end
    alu_valid = 1'b0; fflags_clr = 1'b0;
    fflags_m = clr ? exp_flg : (fflags_m | exp_flg);

    chk("resp_latency", got, exp_cyc);
    chk("resp_result", resp_result, exp_res);
    chk("resp_flags", resp_flags, exp_flg);
    chk("resp_timeout", resp_timeout, exp_to);
    chk("fflags_capture", fflags, fflags_m);

    if (exp_to) begin
      alu_valid = 1'b1; alu_result = 32'h1234_5678; alu_flags = 5'b00111;
      tick();
      alu_valid = 1'b0;
      chk("late_valid_result", resp_result, 32'h7FC0_0000);
      chk("late_valid_flags", fflags, fflags_m);
    end

    for (int i = 0; i < bp; i++) begin
      tick();
      chk("bp_valid", resp_valid, 1);
      chk("bp_result", resp_result, exp_res);
      chk("bp_flags", resp_flags, exp_flg);
      chk("bp_timeout", resp_timeout, exp_to);
      chk("bp_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("resp_valid_drop", resp_valid, 0);
    if (exp_to) chk("drain_busy", busy, 1);
    else begin
      chk("req_ready_after", req_ready, 1);
      chk("busy_after", busy, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_sub = 1'b0;
    req_round_mode = 1'b0; resp_ready = 1'b0; alu_result = '0; alu_valid = 1'b0;
    alu_flags = '0; fflags_clr = 1'b0; fflags_m = '0;
    #12;
    chk_reset_vals("por");
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk_reset_vals("post_rst");

    run_op(32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 1, 32'h4040_0000, 5'b00000, 0, 1'b0);
    run_op(32'h4040_0000, 32'h3F80_0000, 1'b1, 1'b1, 2, 32'h4000_0000, 5'b00000, 0, 1'b0);
    run_op(32'h7F80_0000, 32'hFF80_0000, 1'b0, 1'b0, 0, 32'h7FC0_0000, 5'b01000, 0, 1'b0);
    chk("fflags_invalid", fflags[3], 1);
    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 3, 32'h4000_0000, 5'b00100, 5, 1'b0);
    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 2, 32'h4000_0001, 5'b00100, 0, 1'b1);
    chk("fflags_clr_capture", fflags, 5'b00100);
    run_op(32'h4110_0000, 32'h4120_0000, 1'b1, 1'b0, TO, 32'hBF80_0000, 5'b00001, 1, 1'b0);
    run_op(32'h4110_0000, 32'h4120_0000, 1'b0, 1'b1, 1000, 32'h0, 5'b00000, 2, 1'b0);

    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    fflags_m = '0;
    chk("fflags_clr_idle", fflags, 0);

    for (int i = 0; i < 20; i++)
      run_op($urandom(), $urandom(), 1'($urandom()), 1'($urandom()), $urandom_range(0, 8),
             $urandom(), 5'($urandom()), $urandom_range(0, 3), ($urandom_range(0, 4) == 0));

    begin
      int n = 0;
      while (!req_ready && n < 3 * TO) begin tick(); n++; end
    end
    req_valid = 1'b1; req_a = 32'hDEAD_BEEF; req_b = 32'h8000_0001; req_sub = 1'b1;
    req_round_mode = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    chk("mid_wait_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk); rst_n = 1'b1;
    alu_valid = 1'b1; alu_result = 32'hCAFE_F00D; alu_flags = 5'b11111;
    repeat (3) tick();
    alu_valid = 1'b0;
    chk_reset_vals("stale_valid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
